rf_wb_queue: RTL and testbench

- Write-side front end for the 8x16 register file.
- Buffers register writebacks from the execute path and the variable-latency memory path (the cache stalls).
- Drains one entry per cycle onto the register file's single write port (writeRegSel/writeData/writeEn).
- Gives decode a pending-write hazard flag and youngest-data forwarding for its two read selects, so decode sees architecturally current values.

---
 rtl/rf_wb_queue_pkg.sv | 28 ++
 rtl/rf_wb_queue_match.sv | 47 ++++
 rtl/rf_wb_queue.sv | 119 +++++++++++
 tb/tb_rf_wb_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_queue_pkg.sv
// Shared widths and types for the 8x16 register file and its writeback queue.
// Both the register file and the queue front end import this package.
package rf_wb_queue_pkg;

    localparam int REG_SEL_W = 3;
    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;

    localparam int WBQ_DEPTH = 4;
    localparam int WBQ_PTR_W = 2;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;
    typedef logic [DATA_W-1:0]    rf_data_t;

    typedef enum logic [1:0] {
        WBQ_IDLE = 2'b00,
        WBQ_PUSH = 2'b10,
        WBQ_POP  = 2'b01,
        WBQ_BOTH = 2'b11
    } wbq_op_e;

    // An entry matches a decode select only while it is still queued.
    function automatic logic wbq_sel_match(input logic valid, input reg_sel_t entry_sel,
                                           input reg_sel_t chk_sel);
        return valid && (entry_sel == chk_sel);
    endfunction

endpackage

// File: rtl/rf_wb_queue_match.sv
// Youngest-match search over the queued writebacks for one decode read select.
// Scans from tail-1 back towards head so the most recent write to a register wins.
module wbq_match
    import rf_wb_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int PTR_W = WBQ_PTR_W
) (
    input  reg_sel_t               i_sel,
    input  reg_sel_t [DEPTH-1:0]   i_regs,
    input  rf_data_t [DEPTH-1:0]   i_data,
    input  logic     [DEPTH-1:0]   i_valid,
    input  logic     [PTR_W-1:0]   i_head,
    input  logic     [PTR_W-1:0]   i_tail,
    output logic                   o_hit,
    output rf_data_t               o_data
);

    logic     w_hit;
    rf_data_t w_data;

    // Priority search: first valid match walking backward from the newest entry.
    always_comb begin
        logic             v_done;
        logic [PTR_W-1:0] v_idx;
        w_hit  = 1'b0;
        w_data = '0;
        v_done = 1'b0;
        v_idx  = i_tail;
        for (int k = 1; k <= DEPTH; k++) begin
            v_idx = i_tail - PTR_W'(k);
            if (!v_done && wbq_sel_match(i_valid[v_idx], i_regs[v_idx], i_sel)) begin
                w_hit  = 1'b1;
                w_data = i_data[v_idx];
                v_done = 1'b1;
            end else if (v_idx == i_head) begin
                v_done = 1'b1;
            end else begin
                v_done = v_done;
            end
        end
    end

    assign o_hit  = w_hit;
    assign o_data = w_data;

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue in front of the register file's single write port.
// Drains one entry per cycle and gives decode hazard flags plus youngest-data forwarding.
module rf_wb_queue
    import rf_wb_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int PTR_W = WBQ_PTR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [REG_SEL_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 wb_ready,
    input  logic                 hold,
    output logic [REG_SEL_W-1:0] writeRegSel,
    output logic [DATA_W-1:0]    writeData,
    output logic                 writeEn,
    input  logic [REG_SEL_W-1:0] chkReg1Sel,
    input  logic [REG_SEL_W-1:0] chkReg2Sel,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic [DATA_W-1:0]    fwdData1,
    output logic [DATA_W-1:0]    fwdData2,
    output logic                 err
);

    reg_sel_t [DEPTH-1:0] r_reg;
    rf_data_t [DEPTH-1:0] r_data;
    logic     [DEPTH-1:0] r_valid;
    logic     [PTR_W-1:0] r_head;
    logic     [PTR_W-1:0] r_tail;
    logic     [PTR_W:0]   r_count;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic     [PTR_W:0]   w_count_nxt;
    wbq_op_e              w_op;
    logic                 w_hit1;
    logic                 w_hit2;
    rf_data_t             w_fwd1;
    rf_data_t             w_fwd2;

    // Full compare uses registered count only, so a pop never reopens the queue in the same cycle.
    assign w_ready = (r_count != (PTR_W+1)'(DEPTH));
    assign w_push  = wb_valid & w_ready;
    // Gating with rst keeps a reset cycle from committing a half-discarded queue.
    assign w_pop   = (r_count != (PTR_W+1)'(0)) & ~hold & ~rst;
    assign w_op    = wbq_op_e'({w_push, w_pop});

    // Occupancy update for push, pop or both.
    always_comb begin
        case (w_op)
            WBQ_PUSH: w_count_nxt = r_count + (PTR_W+1)'(1);
            WBQ_POP:  w_count_nxt = r_count - (PTR_W+1)'(1);
            WBQ_BOTH: w_count_nxt = r_count;
            WBQ_IDLE: w_count_nxt = r_count;
            default:  w_count_nxt = r_count;
        endcase
    end

    // Queue storage and pointers; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg   <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_reg[r_tail]   <= wb_reg;
                r_data[r_tail]  <= wb_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    wbq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match1 (
        .i_sel   (chkReg1Sel),
        .i_regs  (r_reg),
        .i_data  (r_data),
        .i_valid (r_valid),
        .i_head  (r_head),
        .i_tail  (r_tail),
        .o_hit   (w_hit1),
        .o_data  (w_fwd1)
    );

    wbq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match2 (
        .i_sel   (chkReg2Sel),
        .i_regs  (r_reg),
        .i_data  (r_data),
        .i_valid (r_valid),
        .i_head  (r_head),
        .i_tail  (r_tail),
        .o_hit   (w_hit2),
        .o_data  (w_fwd2)
    );

    assign wb_ready    = w_ready;
    assign writeEn     = w_pop;
    assign writeRegSel = r_reg[r_head];
    assign writeData   = r_data[r_head];
    assign hazard1     = w_hit1;
    assign hazard2     = w_hit2;
    assign fwdData1    = w_fwd1;
    assign fwdData2    = w_fwd2;
    assign err         = 1'b0;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue with a small register-file model on the write port.
module tb_rf_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        wb_ready;
    logic        hold;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        writeEn;
    logic [2:0]  chkReg1Sel;
    logic [2:0]  chkReg2Sel;
    logic        hazard1;
    logic        hazard2;
    logic [15:0] fwdData1;
    logic [15:0] fwdData2;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [15:0] rf_model [8];
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    rf_wb_queue dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .wb_ready(wb_ready), .hold(hold), .writeRegSel(writeRegSel), .writeData(writeData),
        .writeEn(writeEn), .chkReg1Sel(chkReg1Sel), .chkReg2Sel(chkReg2Sel),
        .hazard1(hazard1), .hazard2(hazard2), .fwdData1(fwdData1), .fwdData2(fwdData2),
        .err(err)
    );

    // Register file model: commits the write port on the rising edge.
    always @(posedge clk) begin
        if (writeEn) begin
            rf_model[writeRegSel] <= writeData;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_valid = 1'b0; wb_reg = 3'd0; wb_data = 16'h0000; hold = 1'b0;
        chkReg1Sel = 3'd0; chkReg2Sel = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (writeEn !== 1'b0) begin bad++; $display("FAIL reset_writeEn got=%b exp=0", writeEn); end
        total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL reset_wb_ready got=%b exp=1", wb_ready); end
        total++; if ({hazard1, hazard2} !== 2'b00) begin bad++; $display("FAIL reset_hazard got=%b%b exp=00", hazard1, hazard2); end
        total++; if ({fwdData1, fwdData2} !== 32'h0) begin bad++; $display("FAIL reset_fwd got=%h/%h exp=0/0", fwdData1, fwdData2); end
        total++; if ({writeRegSel, writeData} !== 19'h0) begin bad++; $display("FAIL reset_port got=%0d/%h exp=0/0", writeRegSel, writeData); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_single();
        int start;
        start = wr_cnt;
        wb_valid = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234; chkReg1Sel = 3'd3;
        tick();
        wb_valid = 1'b0;
        total++; if (writeEn !== 1'b1) begin bad++; $display("FAIL single_writeEn got=%b exp=1", writeEn); end
        total++; if (writeRegSel !== 3'd3) begin bad++; $display("FAIL single_sel got=%0d exp=3", writeRegSel); end
        total++; if (writeData !== 16'h1234) begin bad++; $display("FAIL single_data got=%h exp=1234", writeData); end
        total++; if ({hazard1, fwdData1} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL single_fwd_head got=%b/%h exp=1/1234", hazard1, fwdData1); end
        tick();
        total++; if (rf_model[3] !== 16'h1234) begin bad++; $display("FAIL single_rf got=%h exp=1234", rf_model[3]); end
        total++; if (writeEn !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", writeEn); end
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL single_hazard_gone got=%b exp=0", hazard1); end
        total++; if (wr_cnt - start !== 1) begin bad++; $display("FAIL single_wrcnt got=%0d exp=1", wr_cnt - start); end
    endtask

    task automatic test_fill_hold();
        int start;
        start = wr_cnt;
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wb_valid = 1'b1; wb_reg = 3'(k); wb_data = 16'(k * 16'h0011);
            tick();
        end
        total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b exp=0", wb_ready); end
        total++; if (writeEn !== 1'b0) begin bad++; $display("FAIL fill_hold_writeEn got=%b exp=0", writeEn); end
        total++; if ({writeRegSel, writeData} !== {3'd1, 16'h0011}) begin bad++; $display("FAIL fill_head got=%0d/%h exp=1/0011", writeRegSel, writeData); end
        wb_reg = 3'd7; wb_data = 16'h0077; chkReg1Sel = 3'd7;
        tick();
        wb_valid = 1'b0;
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL fill_fifth_dropped got=%b exp=0", hazard1); end
        total++; if (wb_ready !== 1'b0) begin bad++; $display("FAIL fill_still_full got=%b exp=0", wb_ready); end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (writeEn !== 1'b1) begin bad++; $display("FAIL drain_writeEn_%0d got=%b exp=1", i, writeEn); end
            total++; if (writeRegSel !== 3'(i + 1)) begin bad++; $display("FAIL drain_sel_%0d got=%0d exp=%0d", i, writeRegSel, i + 1); end
            total++; if (writeData !== 16'((i + 1) * 16'h0011)) begin bad++; $display("FAIL drain_data_%0d got=%h exp=%h", i, writeData, 16'((i + 1) * 16'h0011)); end
            total++; if (wb_ready !== (i != 0)) begin bad++; $display("FAIL drain_ready_%0d got=%b exp=%b", i, wb_ready, (i != 0)); end
            tick();
        end
        total++; if (writeEn !== 1'b0) begin bad++; $display("FAIL drain_done got=%b exp=0", writeEn); end
        total++; if (wr_cnt - start !== 4) begin bad++; $display("FAIL drain_count got=%0d exp=4", wr_cnt - start); end
        total++; if (rf_model[4] !== 16'h0044) begin bad++; $display("FAIL drain_rf4 got=%h exp=0044", rf_model[4]); end
    endtask

    task automatic test_forward();
        hold = 1'b1; chkReg1Sel = 3'd5; chkReg2Sel = 3'd2;
        wb_valid = 1'b1; wb_reg = 3'd5; wb_data = 16'hAAAA;
        tick();
        wb_data = 16'hBBBB;
        tick();
        wb_valid = 1'b0;
        total++; if ({hazard1, fwdData1} !== {1'b1, 16'hBBBB}) begin bad++; $display("FAIL fwd_youngest got=%b/%h exp=1/bbbb", hazard1, fwdData1); end
        total++; if ({hazard2, fwdData2} !== {1'b0, 16'h0000}) begin bad++; $display("FAIL fwd_nomatch got=%b/%h exp=0/0000", hazard2, fwdData2); end
        total++; if ({writeEn, writeRegSel, writeData} !== {1'b0, 3'd5, 16'hAAAA}) begin bad++; $display("FAIL fwd_head_held got=%b/%0d/%h exp=0/5/aaaa", writeEn, writeRegSel, writeData); end
        hold = 1'b0;
        tick();
        total++; if (rf_model[5] !== 16'hAAAA) begin bad++; $display("FAIL fwd_rf_first got=%h exp=aaaa", rf_model[5]); end
        total++; if ({hazard1, fwdData1} !== {1'b1, 16'hBBBB}) begin bad++; $display("FAIL fwd_after_pop got=%b/%h exp=1/bbbb", hazard1, fwdData1); end
        tick();
        total++; if (rf_model[5] !== 16'hBBBB) begin bad++; $display("FAIL fwd_rf_last got=%h exp=bbbb", rf_model[5]); end
        total++; if ({hazard1, fwdData1} !== {1'b0, 16'h0000}) begin bad++; $display("FAIL fwd_cleared got=%b/%h exp=0/0000", hazard1, fwdData1); end
    endtask

    task automatic test_stream();
        int start;
        start = wr_cnt;
        hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1'b1; wb_reg = 3'(i % 8); wb_data = 16'(16'h1000 + i);
            tick();
            total++; if ({writeEn, writeRegSel} !== {1'b1, 3'(i % 8)}) begin bad++; $display("FAIL stream_sel_%0d got=%b/%0d exp=1/%0d", i, writeEn, writeRegSel, i % 8); end
            total++; if (writeData !== 16'(16'h1000 + i)) begin bad++; $display("FAIL stream_data_%0d got=%h exp=%h", i, writeData, 16'(16'h1000 + i)); end
            total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%b exp=1", i, wb_ready); end
        end
        wb_valid = 1'b0;
        tick();
        total++; if (writeEn !== 1'b0) begin bad++; $display("FAIL stream_empty got=%b exp=0", writeEn); end
        total++; if (wr_cnt - start !== 10) begin bad++; $display("FAIL stream_count got=%0d exp=10", wr_cnt - start); end
        total++; if (rf_model[1] !== 16'h1009) begin bad++; $display("FAIL stream_rf1 got=%h exp=1009", rf_model[1]); end
    endtask

    task automatic test_reset_mid();
        int start;
        hold = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wb_valid = 1'b1; wb_reg = 3'(2 * k); wb_data = 16'(k * 16'h2222);
            tick();
        end
        start = wr_cnt;
        rst = 1'b1; hold = 1'b0; wb_valid = 1'b1; wb_reg = 3'd1; wb_data = 16'hDEAD;
        chkReg1Sel = 3'd2; chkReg2Sel = 3'd1;
        #1;
        total++; if (writeEn !== 1'b0) begin bad++; $display("FAIL rstmid_no_write_in_reset got=%b exp=0", writeEn); end
        tick();
        rst = 1'b0; wb_valid = 1'b0;
        #1;
        total++; if ({writeEn, wb_ready} !== 2'b01) begin bad++; $display("FAIL rstmid_state got=%b/%b exp=0/1", writeEn, wb_ready); end
        total++; if ({hazard1, hazard2} !== 2'b00) begin bad++; $display("FAIL rstmid_hazard got=%b%b exp=00", hazard1, hazard2); end
        total++; if ({writeRegSel, writeData} !== 19'h0) begin bad++; $display("FAIL rstmid_port got=%0d/%h exp=0/0", writeRegSel, writeData); end
        tick();
        total++; if (wr_cnt - start !== 0) begin bad++; $display("FAIL rstmid_writes got=%0d exp=0", wr_cnt - start); end
        total++; if (rf_model[1] !== 16'h1009) begin bad++; $display("FAIL rstmid_rf1 got=%h exp=1009", rf_model[1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_hold();
        test_forward();
        test_stream();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
